// File: rtl/run_controller_pkg.sv
// run_controller_pkg
// Shared definitions for the run-control sequencer:
//   - run_state_t : the encoding of the sequencer states, which is also
//                   the value presented on the o_state port
//   - BP_ADDR_WIDTH : width of an instruction address / breakpoint address
package run_controller_pkg;

  localparam int BP_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_HALT = 2'b01,
    ST_RUN  = 2'b10,
    ST_STEP = 2'b11
  } run_state_t;

endpackage

// File: rtl/run_controller_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; forces count to 0
//   clear  - synchronous clear; wins over enable in the same cycle
//   enable - count this cycle
//   count  - current count value
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // Clear beats increment; once all-ones the value is frozen until cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/run_controller.sv
// run_controller
// Run-control sequencer for the 16-bit CPU core. It holds the core in a
// clear state after reset, then gates the core's state-update enable to
// provide halt, free run, N-cycle single step and one instruction-address
// breakpoint.
// Ports:
//   i_clock, i_reset        - clock and synchronous active-high reset
//   i_run, i_halt, i_step   - command pulses (run/step from HALT only,
//                             halt from RUN or STEP only)
//   i_stepCount             - cycles to execute on a step; 0 means 1
//   i_bpWrite, i_bpAddr,
//   i_bpEnable              - load the breakpoint address/enable registers
//   i_clrCount              - clear the executed-cycle counter
//   i_instrAddr             - current instruction pointer of the core
//   o_cpuEn                 - core write enable (combinational)
//   o_cpuRst                - core clear pulse while in HOLD
//   o_state                 - HOLD=00, HALT=01, RUN=10, STEP=11
//   o_bpHit                 - sticky: execution stopped at the breakpoint
//   o_cycleCount            - saturating count of enabled cycles
module run_controller
  import run_controller_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int STEP_WIDTH  = 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_run,
  input  logic                   i_halt,
  input  logic                   i_step,
  input  logic [0:STEP_WIDTH-1]  i_stepCount,
  input  logic                   i_bpWrite,
  input  logic [0:15]            i_bpAddr,
  input  logic                   i_bpEnable,
  input  logic                   i_clrCount,
  input  logic [0:15]            i_instrAddr,
  output logic                   o_cpuEn,
  output logic                   o_cpuRst,
  output logic [0:1]             o_state,
  output logic                   o_bpHit,
  output logic [0:CNT_WIDTH-1]   o_cycleCount
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  run_state_t                   state, state_next;
  logic [HOLD_W-1:0]            hold_cnt, hold_next;
  logic [STEP_WIDTH-1:0]        step_rem, step_next;
  logic [BP_ADDR_WIDTH-1:0]     bp_addr;
  logic                         bp_en;
  logic                         skip_bp, skip_next;
  logic                         bp_hit, hit_next;
  logic                         bp_match;
  logic                         cpu_en;
  logic [CNT_WIDTH-1:0]         cycle_count;

  // skip_bp masks the compare for the first executed cycle after a resume,
  // so the instruction sitting at the breakpoint can finally execute.
  assign bp_match = bp_en && (i_instrAddr == bp_addr) && !skip_bp;
  assign cpu_en   = ((state == ST_RUN) || (state == ST_STEP)) && !bp_match && !i_reset;

  assign o_cpuEn      = cpu_en;
  assign o_cpuRst     = (state == ST_HOLD);
  assign o_state      = state;
  assign o_bpHit      = bp_hit;
  assign o_cycleCount = cycle_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= ST_HOLD;
      hold_cnt <= '0;
      step_rem <= '0;
      skip_bp  <= 1'b0;
      bp_hit   <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      step_rem <= step_next;
      skip_bp  <= skip_next;
      bp_hit   <= hit_next;
    end
  end

  // Breakpoint registers are writable in every state; the compare only
  // ever sees the registered copy, so a write affects the following cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bp_addr <= '0;
      bp_en   <= 1'b0;
    end else if (i_bpWrite) begin
      bp_addr <= i_bpAddr;
      bp_en   <= i_bpEnable;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    step_next  = step_rem;
    skip_next  = skip_bp;
    hit_next   = bp_hit;

    if (cpu_en) begin
      skip_next = 1'b0;
    end

    case (state)
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next = ST_HALT;
          hold_next  = '0;
        end else begin
          hold_next = hold_cnt + HOLD_W'(1);
        end
      end
      ST_HALT: begin
        // Step wins over run when both arrive together.
        if (i_step) begin
          state_next = ST_STEP;
          step_next  = (i_stepCount == '0) ? STEP_WIDTH'(1) : i_stepCount;
          hit_next   = 1'b0;
          skip_next  = 1'b1;
        end else if (i_run) begin
          state_next = ST_RUN;
          hit_next   = 1'b0;
          skip_next  = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          state_next = ST_HALT;
        end else if (bp_match) begin
          state_next = ST_HALT;
          hit_next   = 1'b1;
        end
      end
      ST_STEP: begin
        if (i_halt) begin
          state_next = ST_HALT;
        end else if (bp_match) begin
          state_next = ST_HALT;
          hit_next   = 1'b1;
          step_next  = '0;
        end else if (cpu_en) begin
          step_next = step_rem - STEP_WIDTH'(1);
          if (step_rem == STEP_WIDTH'(1)) begin
            state_next = ST_HALT;
          end
        end
      end
      default: begin
        state_next = ST_HOLD;
      end
    endcase
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_cycle_counter (
    .clock (i_clock),
    .reset (i_reset),
    .clear (i_clrCount),
    .enable(cpu_en),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller
// Directed scenarios followed by a long randomized run, all checked every
// cycle against a behavioural reference model of the run controller.
// The counter is built 8 bits wide so saturation is reachable quickly.
module tb_run_controller;

  localparam int HOLD_CYCLES = 4;
  localparam int STEP_WIDTH  = 8;
  localparam int CNT_WIDTH   = 8;
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;

  localparam int M_HOLD = 0;
  localparam int M_HALT = 1;
  localparam int M_RUN  = 2;
  localparam int M_STEP = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  run_cmd;
  logic                  halt_cmd;
  logic                  step_cmd;
  logic [STEP_WIDTH-1:0] step_count;
  logic                  bp_write;
  logic [15:0]           bp_addr_in;
  logic                  bp_enable_in;
  logic                  clr_count;
  logic [15:0]           instr_addr;
  logic                  cpu_en;
  logic                  cpu_rst;
  logic [1:0]            state;
  logic                  bp_hit;
  logic [CNT_WIDTH-1:0]  cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, written only by the stimulus process.
  bit          m_valid = 1'b0;
  int          m_mode;
  int          m_hold_left;
  int          m_steps_left;
  int          m_bp_addr;
  bit          m_bp_on;
  bit          m_skip;
  bit          m_hit;
  int          m_count;
  bit          m_en = 1'b0;

  // Emulated core instruction pointer: advances whenever the model says
  // the core was enabled, or a fixed address is presented instead.
  bit          follow_ip = 1'b0;
  logic [15:0] ip_track  = 16'h0000;
  logic [15:0] ip_fixed  = 16'h0000;

  always #5 clk = ~clk;

  run_controller #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .STEP_WIDTH (STEP_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .i_clock     (clk),
    .i_reset     (reset),
    .i_run       (run_cmd),
    .i_halt      (halt_cmd),
    .i_step      (step_cmd),
    .i_stepCount (step_count),
    .i_bpWrite   (bp_write),
    .i_bpAddr    (bp_addr_in),
    .i_bpEnable  (bp_enable_in),
    .i_clrCount  (clr_count),
    .i_instrAddr (instr_addr),
    .o_cpuEn     (cpu_en),
    .o_cpuRst    (cpu_rst),
    .o_state     (state),
    .o_bpHit     (bp_hit),
    .o_cycleCount(cycle_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs shortly after the rising edge and let the
  // combinational enable settle before anything looks at it.
  task automatic applyStimulus(input bit rst, input bit run, input bit halt,
                               input bit step, input int cnt, input bit clr,
                               input bit bpw, input int bpa, input bit bpe);
    reset        = rst;
    run_cmd      = run;
    halt_cmd     = halt;
    step_cmd     = step;
    step_count   = STEP_WIDTH'(cnt);
    clr_count    = clr;
    bp_write     = bpw;
    bp_addr_in   = 16'(bpa);
    bp_enable_in = bpe;
    instr_addr   = follow_ip ? ip_track : ip_fixed;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Expected outputs for the current cycle from the model's view of the
  // world, compared against every DUT output.
  task automatic modelCheck();
    bit match;
    match = m_bp_on && (int'(instr_addr) == m_bp_addr) && !m_skip;
    m_en  = ((m_mode == M_RUN) || (m_mode == M_STEP)) && !match && !reset;
    if (m_valid) begin
      checkOutput("model_state",  32'(state),       32'(m_mode));
      checkOutput("model_cpuEn",  32'(cpu_en),      32'(m_en));
      checkOutput("model_cpuRst", 32'(cpu_rst),     32'(m_mode == M_HOLD));
      checkOutput("model_bpHit",  32'(bp_hit),      32'(m_hit));
      checkOutput("model_count",  32'(cycle_count), 32'(m_count));
    end
  endtask

  // What the clock edge does, from the rules of the controller.
  task automatic modelAdvance();
    bit match;
    match = m_bp_on && (int'(instr_addr) == m_bp_addr) && !m_skip;
    if (m_en) ip_track = ip_track + 16'd1;
    if (reset) begin
      m_valid      = 1'b1;
      m_mode       = M_HOLD;
      m_hold_left  = HOLD_CYCLES;
      m_steps_left = 0;
      m_bp_addr    = 0;
      m_bp_on      = 1'b0;
      m_skip       = 1'b0;
      m_hit        = 1'b0;
      m_count      = 0;
    end else if (m_valid) begin
      if (clr_count) m_count = 0;
      else if (m_en && m_count < CNT_MAX) m_count = m_count + 1;
      if (m_en) m_skip = 1'b0;
      case (m_mode)
        M_HOLD: begin
          m_hold_left = m_hold_left - 1;
          if (m_hold_left == 0) m_mode = M_HALT;
        end
        M_HALT: begin
          if (step_cmd) begin
            m_mode       = M_STEP;
            m_steps_left = (step_count == 0) ? 1 : int'(step_count);
            m_hit        = 1'b0;
            m_skip       = 1'b1;
          end else if (run_cmd) begin
            m_mode = M_RUN;
            m_hit  = 1'b0;
            m_skip = 1'b1;
          end
        end
        M_RUN: begin
          if (halt_cmd) m_mode = M_HALT;
          else if (match) begin
            m_mode = M_HALT;
            m_hit  = 1'b1;
          end
        end
        default: begin
          if (halt_cmd) m_mode = M_HALT;
          else if (match) begin
            m_mode       = M_HALT;
            m_hit        = 1'b1;
            m_steps_left = 0;
          end else if (m_en) begin
            m_steps_left = m_steps_left - 1;
            if (m_steps_left == 0) m_mode = M_HALT;
          end
        end
      endcase
      if (bp_write) begin
        m_bp_addr = int'(bp_addr_in);
        m_bp_on   = bp_enable_in;
      end
    end
  endtask

  task automatic tick();
    modelCheck();
    modelAdvance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int en_sum;
    int rst_cycles;

    // Reset and the HOLD window.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    rst_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (cpu_rst !== 1'b1) break;
      rst_cycles++;
      tick();
    end
    checkOutput("hold_cycles", 32'(rst_cycles), 32'd4);
    checkOutput("post_hold_state", 32'(state), 32'd1);
    checkOutput("post_hold_cpuEn", 32'(cpu_en), 32'd0);
    checkOutput("post_hold_count", 32'(cycle_count), 32'd0);
    tick();

    // Step of 3, then step of 0 (treated as 1).
    applyStimulus(0, 0, 0, 1, 3, 0, 0, 0, 0);
    checkOutput("step3_cmd_cycle_en", 32'(cpu_en), 32'd0);
    tick();
    en_sum = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      en_sum += int'(cpu_en);
      tick();
    end
    checkOutput("step3_enabled", 32'(en_sum), 32'd3);
    idle();
    checkOutput("step3_state", 32'(state), 32'd1);
    checkOutput("step3_count", 32'(cycle_count), 32'd3);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    en_sum = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      en_sum += int'(cpu_en);
      tick();
    end
    checkOutput("step0_enabled", 32'(en_sum), 32'd1);

    // Breakpoint at 0x0005 with the IP counting up from 0.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 1);
    tick();
    follow_ip = 1'b1;
    ip_track  = 16'h0000;
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    en_sum = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (state == 2'b01) break;
      en_sum += int'(cpu_en);
      tick();
    end
    checkOutput("bp_enabled_before_stop", 32'(en_sum), 32'd5);
    checkOutput("bp_state", 32'(state), 32'd1);
    checkOutput("bp_hit_set", 32'(bp_hit), 32'd1);
    checkOutput("bp_count", 32'(cycle_count), 32'd9);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    checkOutput("bp_resume_en", 32'(cpu_en), 32'd1);
    checkOutput("bp_resume_hit_clear", 32'(bp_hit), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      tick();
    end
    idle();
    checkOutput("bp_no_restop", 32'(state), 32'd2);
    tick();
    // Halt during RUN: the halt cycle still executes, the next one does not.
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_cycle_en", 32'(cpu_en), 32'd1);
    tick();
    idle();
    checkOutput("after_halt_state", 32'(state), 32'd1);
    checkOutput("after_halt_en", 32'(cpu_en), 32'd0);
    tick();
    follow_ip = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();

    // Run and step together: step of 2 wins.
    applyStimulus(0, 1, 0, 1, 2, 0, 0, 0, 0);
    tick();
    en_sum = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i == 0) checkOutput("run_step_state", 32'(state), 32'd3);
      en_sum += int'(cpu_en);
      tick();
    end
    checkOutput("run_step_enabled", 32'(en_sum), 32'd2);

    // Counter saturation and clear-over-increment.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 300; i++) begin
      idle();
      tick();
    end
    idle();
    checkOutput("sat_count", 32'(cycle_count), 32'(CNT_MAX));
    checkOutput("sat_state", 32'(state), 32'd2);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("clr_cycle_en", 32'(cpu_en), 32'd1);
    tick();
    idle();
    checkOutput("clr_count", 32'(cycle_count), 32'd0);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();

    // Breakpoint hit on a static IP, then reset in the middle of a long step.
    ip_fixed = 16'h0003;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 1);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    checkOutput("static_bp_skip_en", 32'(cpu_en), 32'd1);
    tick();
    idle();
    checkOutput("static_bp_match_en", 32'(cpu_en), 32'd0);
    tick();
    idle();
    checkOutput("static_bp_hit", 32'(bp_hit), 32'd1);
    tick();
    ip_fixed = 16'h0009;
    applyStimulus(0, 0, 0, 1, 100, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      idle();
      tick();
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_cycle_en", 32'(cpu_en), 32'd0);
    checkOutput("reset_cycle_state", 32'(state), 32'd3);
    tick();
    idle();
    checkOutput("after_reset_state", 32'(state), 32'd0);
    checkOutput("after_reset_hit", 32'(bp_hit), 32'd0);
    checkOutput("after_reset_cpuRst", 32'(cpu_rst), 32'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      idle();
      if (state == 2'b01) break;
      tick();
    end
    checkOutput("reset_back_to_halt", 32'(state), 32'd1);
    tick();
    ip_fixed = 16'h0003;
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    tick();
    idle();
    checkOutput("bp_cleared_en", 32'(cpu_en), 32'd1);
    checkOutput("bp_cleared_state", 32'(state), 32'd2);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();

    // Randomized traffic with a small address space so breakpoints fire.
    for (int i = 0; i < 3000; i++) begin
      ip_fixed = 16'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 5)),
                    ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 19) == 0),
                    int'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
